isp8_io_timer: RTL and testbench

- 16-bit programmable interval timer with interrupt output, mapped on the Mico8 external I/O bus.
- Decodes the CPU's 8-bit I/O address and consumes its I/O write and read strobes.
- Returns read data to the CPU's I/O input mux.
- Drives the CPU interrupt request and clears it on the CPU interrupt acknowledge.

---
 rtl/isp8_io_timer_if.sv | 21 ++
 rtl/isp8_io_timer.sv | 141 ++++++++++++++
 tb/tb_isp8_io_timer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isp8_io_timer_if.sv
// Mico8 external I/O bus as seen by a peripheral, plus the interrupt request/acknowledge pair.
// The CPU side uses the master modport, the peripheral side uses the slave modport.
interface isp8_io_timer_if;
    logic [7:0] io_addr;
    logic [7:0] io_wdata;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] io_rdata;
    logic       intr;
    logic       intr_ack;

    modport master (
        output io_addr, io_wdata, io_wr, io_rd, intr_ack,
        input  io_rdata, intr
    );

    modport slave (
        input  io_addr, io_wdata, io_wr, io_rd, intr_ack,
        output io_rdata, intr
    );
endinterface

// File: rtl/isp8_io_timer.sv
// 16-bit programmable interval timer with prescaler and interrupt, on the Mico8 external I/O bus.
// io_rdata is 8'h00 when the block is not being read, so it can be OR-combined with other peripherals.
module isp8_io_timer #(
    parameter logic [7:0] BASE_ADDR    = 8'h10,
    parameter logic [7:0] PRESCALE_RST = 8'h00
) (
    input logic            clk,
    input logic            rst_n,
    isp8_io_timer_if.slave io
);
    localparam logic [2:0] OffCtrl     = 3'd0;
    localparam logic [2:0] OffPrescale = 3'd1;
    localparam logic [2:0] OffReloadLo = 3'd2;
    localparam logic [2:0] OffReloadHi = 3'd3;
    localparam logic [2:0] OffCountLo  = 3'd4;
    localparam logic [2:0] OffCountHi  = 3'd5;
    localparam logic [2:0] OffStatus   = 3'd6;

    logic        sel, wr_en, rd_en;
    logic [2:0]  off;
    logic        tick, expire, start;

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic        flag_q, flag_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  psc_q, psc_d;
    logic [7:0]  snap_hi_q, snap_hi_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;

    assign sel   = (io.io_addr[7:3] == BASE_ADDR[7:3]);
    assign off   = io.io_addr[2:0];
    assign wr_en = sel & io.io_wr;
    assign rd_en = sel & io.io_rd;

    assign tick   = en_q & (psc_q == prescale_q);
    assign expire = tick & (count_q == 16'h0000);
    assign start  = wr_en & (off == OffCtrl) & io.io_wdata[0] & ~en_q;

    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        flag_d     = flag_q;
        prescale_d = prescale_q;
        psc_d      = psc_q;
        snap_hi_d  = snap_hi_q;
        reload_d   = reload_q;
        count_d    = count_q;

        if (start) begin
            psc_d = 8'h00;
        end else if (en_q) begin
            psc_d = tick ? 8'h00 : psc_q + 8'h01;
        end

        // Start load takes priority; otherwise a tick still applies even if EN is being cleared.
        if (start) begin
            count_d = reload_q;
        end else if (tick) begin
            if (count_q != 16'h0000) begin
                count_d = count_q - 16'h0001;
            end else if (auto_q) begin
                count_d = reload_q;
            end
        end

        if (expire && !auto_q) begin
            en_d = 1'b0;
        end

        // Expiry set beats both clear sources.
        if (expire) begin
            flag_d = 1'b1;
        end else if (io.intr_ack || (wr_en && (off == OffStatus) && io.io_wdata[0])) begin
            flag_d = 1'b0;
        end

        if (wr_en) begin
            case (off)
                OffCtrl: begin
                    en_d   = io.io_wdata[0];
                    auto_d = io.io_wdata[1];
                    ie_d   = io.io_wdata[2];
                end
                OffPrescale: prescale_d     = io.io_wdata;
                OffReloadLo: reload_d[7:0]  = io.io_wdata;
                OffReloadHi: reload_d[15:8] = io.io_wdata;
                default: ;
            endcase
        end

        if (rd_en && (off == OffCountLo)) begin
            snap_hi_d = count_q[15:8];
        end
    end

    always_comb begin
        io.io_rdata = 8'h00;
        if (rd_en) begin
            case (off)
                OffCtrl:     io.io_rdata = {5'b00000, ie_q, auto_q, en_q};
                OffPrescale: io.io_rdata = prescale_q;
                OffReloadLo: io.io_rdata = reload_q[7:0];
                OffReloadHi: io.io_rdata = reload_q[15:8];
                OffCountLo:  io.io_rdata = count_q[7:0];
                OffCountHi:  io.io_rdata = snap_hi_q;
                OffStatus:   io.io_rdata = {7'b0000000, flag_q};
                default:     io.io_rdata = 8'h00;
            endcase
        end
    end

    assign io.intr = flag_q & ie_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            flag_q     <= 1'b0;
            prescale_q <= PRESCALE_RST;
            psc_q      <= 8'h00;
            snap_hi_q  <= 8'h00;
            reload_q   <= 16'h0000;
            count_q    <= 16'h0000;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            flag_q     <= flag_d;
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
            snap_hi_q  <= snap_hi_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_isp8_io_timer.sv
// Directed bench for isp8_io_timer: register access, one-shot, auto-reload, snapshot reads,
// acknowledge race, reset mid-count and address decode.
module tb_isp8_io_timer;
    localparam logic [7:0] BASE = 8'h10;
    localparam logic [7:0] PRST = 8'h3C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    isp8_io_timer_if bus ();

    isp8_io_timer #(
        .BASE_ADDR    (BASE),
        .PRESCALE_RST (PRST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    // Bus helpers: called at posedge+1, return at posedge+1.
    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        bus.io_addr  = a;
        bus.io_wdata = d;
        bus.io_wr    = 1'b1;
        @(posedge clk);
        #1;
        bus.io_wr    = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d);
        bus.io_addr = a;
        bus.io_rd   = 1'b1;
        #1;
        d = bus.io_rdata;
        @(posedge clk);
        #1;
        bus.io_rd   = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_rst [8];
        logic [7:0] d;
        exp_rst = '{8'h00, PRST, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (bus.intr !== 1'b0) begin
            failures++;
            $display("FAIL reset_intr got=%b exp=0", bus.intr);
        end
        checks++;
        if (bus.io_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle_rdata got=%h exp=00", bus.io_rdata);
        end
        for (int i = 0; i < 8; i++) begin
            io_read(BASE + 8'(i), d);
            checks++;
            if (d !== exp_rst[i]) begin
                failures++;
                $display("FAIL reset_read off=%0d got=%h exp=%h", i, d, exp_rst[i]);
            end
        end
        io_write(BASE + 8'd2, 8'hA5);
        io_read(BASE + 8'd2, d);
        checks++;
        if (d !== 8'hA5) begin
            failures++;
            $display("FAIL reload_lo_rw got=%h exp=a5", d);
        end
        io_write(BASE + 8'd7, 8'hFF);
        io_read(BASE + 8'd7, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL reserved_read got=%h exp=00", d);
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] d;
        io_write(BASE + 8'd1, 8'h00);
        io_write(BASE + 8'd2, 8'h03);
        io_write(BASE + 8'd3, 8'h00);
        io_write(BASE + 8'd0, 8'h05);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.intr !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_early_intr got=%b exp=0", bus.intr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.intr !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_intr got=%b exp=1", bus.intr);
        end
        io_read(BASE + 8'd6, d);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL oneshot_flag got=%h exp=01", d);
        end
        io_read(BASE + 8'd0, d);
        checks++;
        if (d !== 8'h04) begin
            failures++;
            $display("FAIL oneshot_ctrl got=%h exp=04", d);
        end
        repeat (3) @(posedge clk);
        #1;
        io_read(BASE + 8'd4, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL oneshot_count got=%h exp=00", d);
        end
    endtask

    task automatic test_auto_reload();
        io_write(BASE + 8'd6, 8'h01);
        io_write(BASE + 8'd1, 8'h02);
        io_write(BASE + 8'd2, 8'h04);
        io_write(BASE + 8'd0, 8'h07);
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (bus.intr !== 1'b0) begin
            failures++;
            $display("FAIL auto_early_intr got=%b exp=0", bus.intr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.intr !== 1'b1) begin
            failures++;
            $display("FAIL auto_first_intr got=%b exp=1", bus.intr);
        end
        io_write(BASE + 8'd6, 8'h01);
        checks++;
        if (bus.intr !== 1'b0) begin
            failures++;
            $display("FAIL auto_w1c got=%b exp=0", bus.intr);
        end
        repeat (13) @(posedge clk);
        #1;
        checks++;
        if (bus.intr !== 1'b0) begin
            failures++;
            $display("FAIL auto_second_early got=%b exp=0", bus.intr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.intr !== 1'b1) begin
            failures++;
            $display("FAIL auto_second_intr got=%b exp=1", bus.intr);
        end
        io_write(BASE + 8'd0, 8'h00);
        io_write(BASE + 8'd6, 8'h01);
    endtask

    task automatic test_coherent_read();
        logic [7:0] d;
        io_write(BASE + 8'd1, 8'h00);
        io_write(BASE + 8'd2, 8'h00);
        io_write(BASE + 8'd3, 8'h01);
        io_write(BASE + 8'd0, 8'h01);
        io_read(BASE + 8'd4, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL coherent_lo got=%h exp=00", d);
        end
        io_read(BASE + 8'd5, d);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL coherent_hi got=%h exp=01", d);
        end
        io_read(BASE + 8'd4, d);
        checks++;
        if (d !== 8'hFE) begin
            failures++;
            $display("FAIL live_count_lo got=%h exp=fe", d);
        end
        io_write(BASE + 8'd0, 8'h00);
    endtask

    task automatic test_ack_race();
        logic [7:0] d;
        io_write(BASE + 8'd6, 8'h01);
        io_write(BASE + 8'd2, 8'h02);
        io_write(BASE + 8'd3, 8'h00);
        io_write(BASE + 8'd0, 8'h05);
        repeat (2) @(posedge clk);
        #1;
        bus.intr_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.intr_ack = 1'b0;
        checks++;
        if (bus.intr !== 1'b1) begin
            failures++;
            $display("FAIL race_flag_kept got=%b exp=1", bus.intr);
        end
        @(posedge clk);
        #1;
        bus.intr_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.intr_ack = 1'b0;
        checks++;
        if (bus.intr !== 1'b0) begin
            failures++;
            $display("FAIL ack_clear_intr got=%b exp=0", bus.intr);
        end
        io_read(BASE + 8'd6, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL ack_clear_flag got=%h exp=00", d);
        end
    endtask

    task automatic test_reset_mid_decode();
        logic [7:0] d;
        logic [7:0] exp_rst [8];
        exp_rst = '{8'h00, PRST, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        io_write(BASE + 8'd1, 8'h00);
        io_write(BASE + 8'd2, 8'h00);
        io_write(BASE + 8'd0, 8'h05);
        @(posedge clk);
        #1;
        io_write(BASE + 8'd1, 8'hFF);
        io_write(BASE + 8'd2, 8'h50);
        io_write(BASE + 8'd0, 8'h05);
        io_read(BASE + 8'd4, d);
        checks++;
        if (d !== 8'h50 || bus.intr !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup count got=%h exp=50 intr got=%b exp=1", d, bus.intr);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.intr !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_intr got=%b exp=0", bus.intr);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            io_read(BASE + 8'(i), d);
            checks++;
            if (d !== exp_rst[i]) begin
                failures++;
                $display("FAIL mid_reset_read off=%0d got=%h exp=%h", i, d, exp_rst[i]);
            end
        end
        io_write(BASE + 8'd8, 8'h07);
        io_write(BASE + 8'd10, 8'h99);
        io_read(BASE + 8'd0, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL decode_ctrl got=%h exp=00", d);
        end
        io_read(BASE + 8'd2, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL decode_reload got=%h exp=00", d);
        end
        io_read(BASE + 8'd9, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL unselected_rdata got=%h exp=00", d);
        end
    endtask

    initial begin
        bus.io_addr  = 8'h00;
        bus.io_wdata = 8'h00;
        bus.io_wr    = 1'b0;
        bus.io_rd    = 1'b0;
        bus.intr_ack = 1'b0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_coherent_read();
        test_ack_race();
        test_reset_mid_decode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
